i2c_cfg_target: RTL and testbench

I2C target (responder) with an internal byte-addressed register file. It is the opposite end of the HDMI configuration master, which is an I2C initiator. The block presents the ADV7513's bus address so the configuration master can be exercised and regression-tested against it in simulation. On hardware it also exposes a board-side configuration register bank to an external I2C controller. It runs in the 50 MHz configuration clock domain and samples the bus by oversampling; it does not clock on SCL.

---
 rtl/i2c_cfg_target_if.sv | 23 ++
 rtl/i2c_cfg_target.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_cfg_target.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cfg_target_if.sv
// I2C pad levels plus the register-write strobe bus of the configuration target.
// Pure wiring: no latency; the strobe side has no backpressure.
interface i2c_cfg_target_if #(
  parameter int ADDR_W = 8
);
  logic              I2C_SCL_I;
  logic              I2C_SDA_I;
  logic              I2C_SDA_OE;
  logic              WR_STB;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;
  logic              BUSY;

  modport master (
    output I2C_SCL_I, I2C_SDA_I,
    input  I2C_SDA_OE, WR_STB, WR_ADDR, WR_DATA, BUSY
  );

  modport slave (
    input  I2C_SCL_I, I2C_SDA_I,
    output I2C_SDA_OE, WR_STB, WR_ADDR, WR_DATA, BUSY
  );
endinterface

// File: rtl/i2c_cfg_target.sv
// I2C target with a 2**ADDR_W byte register file, oversampled on iCLK; pad-to-event latency 2+FILTER_LEN cycles.
// WR_STB follows the 8th data bit by one cycle; no clock stretching, so the host must take every strobe.
module i2c_cfg_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h39,
  parameter int         ADDR_W     = 8,
  parameter int         FILTER_LEN = 3
) (
  input logic            iCLK,
  input logic            iRST_N,
  i2c_cfg_target_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, ACK, REG, WDATA, RDATA, MACK, IGNORE} state_t;

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0]       pad;
  logic [1:0]       s1_q, s2_q, filt_q, filt_d, rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  state_t            state_q, state_d, ret_q, ret_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        sh_q, sh_d, byte_in;
  logic [ADDR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              oe_q, oe_d, busy_q, busy_d, ack_drv_q, ack_drv_d, wr_stb_q, wr_stb_d;
  logic              mem_we;
  logic [7:0]        mem_q [DEPTH];

  logic scl_rise, scl_fall, start_ev, stop_ev;

  assign pad      = {bus.I2C_SDA_I, bus.I2C_SCL_I};
  assign scl_rise = rise_q[0];
  assign scl_fall = fall_q[0];
  assign start_ev = fall_q[1] & filt_q[0];
  assign stop_ev  = rise_q[1] & filt_q[0];
  assign byte_in  = {sh_q[6:0], filt_q[1]};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      rise_d[i] = 1'b0;
      fall_d[i] = 1'b0;
      cnt_d[i]  = '0;
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_W'(FILTER_LEN - 1)) begin
          filt_d[i] = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    ack_drv_d = ack_drv_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    if (start_ev) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      ack_drv_d = 1'b0;
    end else if (stop_ev) begin
      state_d   = IDLE;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      ack_drv_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, REG, WDATA: begin
          if (scl_rise) begin
            sh_d      = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              state_d   = ACK;
              ret_d     = WDATA;
              case (state_q)
                ADDR: begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                    busy_d = 1'b1;
                    ret_d  = byte_in[0] ? RDATA : REG;
                  end else begin
                    busy_d  = 1'b0;
                    state_d = IGNORE;
                  end
                end
                REG: ptr_d = byte_in[ADDR_W-1:0];
                default: begin
                  mem_we    = 1'b1;
                  wr_stb_d  = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = byte_in;
                  ptr_d     = ptr_q + 1'b1;
                end
              endcase
            end
          end
        end
        ACK: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              oe_d      = 1'b1;
              ack_drv_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              ack_drv_d = 1'b0;
              state_d   = ret_q;
              // The fall that ends the ACK slot also presents the first read bit.
              if (ret_q == RDATA) begin
                oe_d = ~mem_q[ptr_q][7];
                sh_d = {mem_q[ptr_q][6:0], 1'b0};
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d      = 1'b0;
              ptr_d     = ptr_q + 1'b1;
              bit_cnt_d = '0;
              state_d   = MACK;
            end else begin
              oe_d = ~sh_q[7];
              sh_d = {sh_q[6:0], 1'b0};
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (!filt_q[1]) begin
              state_d   = RDATA;
              sh_d      = mem_q[ptr_q];
              bit_cnt_d = '0;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      filt_q    <= 2'b11;
      rise_q    <= '0;
      fall_q    <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      state_q   <= IDLE;
      ret_q     <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      ack_drv_q <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      s1_q      <= pad;
      s2_q      <= s1_q;
      filt_q    <= filt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      ret_q     <= ret_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      ack_drv_q <= ack_drv_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (mem_we) mem_q[ptr_q] <= byte_in;
    end
  end

  assign bus.I2C_SDA_OE = oe_q;
  assign bus.WR_STB     = wr_stb_q;
  assign bus.WR_ADDR    = wr_addr_q;
  assign bus.WR_DATA    = wr_data_q;
  assign bus.BUSY       = busy_q;
endmodule

// File: tb/tb_i2c_cfg_target.sv
// Bench for i2c_cfg_target: bit-banged I2C initiator with a byte-array reference model of the register file.
// Drives directed scenarios plus randomized write/readback bursts and checks ACKs, read data and write strobes.
module tb_i2c_cfg_target;
  localparam int Q = 10;

  logic clk;
  logic rst_n;
  logic scl, m_sda, gl, glitch_arm;
  logic sda_line;

  i2c_cfg_target_if #(.ADDR_W(8)) bus ();

  assign sda_line      = m_sda & ~gl & ~bus.I2C_SDA_OE;
  assign bus.I2C_SCL_I = scl;
  assign bus.I2C_SDA_I = sda_line;

  i2c_cfg_target #(.DEV_ADDR(7'h39), .ADDR_W(8), .FILTER_LEN(3)) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] stb_q[$];
  logic [15:0] exp_q[$];
  int          oe_seen, busy_seen, oe_viol;
  logic        oe_prev;

  logic [7:0] rmem [256];
  logic [7:0] rptr;
  logic [7:0] wbuf [4];

  always @(negedge clk) begin
    if (bus.WR_STB) stb_q.push_back({bus.WR_ADDR, bus.WR_DATA});
    if (bus.I2C_SDA_OE) oe_seen++;
    if (bus.BUSY) busy_seen++;
    if (rst_n && scl && (bus.I2C_SDA_OE !== oe_prev)) oe_viol++;
    oe_prev = bus.I2C_SDA_OE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    m_sda = b;
    wq();
    scl = 1'b1;
    wq();
    r = sda_line;
    if (glitch_arm && b) begin
      gl = 1'b1;
      @(negedge clk);
      gl = 1'b0;
      glitch_arm = 1'b0;
    end
    wq();
    scl = 1'b0;
    wq();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wq();
    scl = 1'b1;
    wq();
    m_sda = 1'b0;
    wq();
    scl = 1'b0;
    wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wq();
    scl = 1'b1;
    wq();
    m_sda = 1'b1;
    wq();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  task automatic chk_stb(input string tag);
    chk({tag, "_stb_count"}, stb_q.size(), exp_q.size());
    while (stb_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_stb"}, stb_q.pop_front(), exp_q.pop_front());
    stb_q.delete();
    exp_q.delete();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
    rptr = 8'h00;
  endtask

  task automatic write_txn(input string tag, input logic [7:0] p, input int n);
    logic ack;
    i2c_start();
    wr_byte(8'h72, ack);
    chk({tag, "_addr_ack"}, ack, 0);
    chk({tag, "_busy_on"}, bus.BUSY, 1);
    wr_byte(p, ack);
    chk({tag, "_reg_ack"}, ack, 0);
    rptr = p;
    for (int i = 0; i < n; i++) begin
      wr_byte(wbuf[i], ack);
      chk({tag, "_data_ack"}, ack, 0);
      exp_q.push_back({rptr, wbuf[i]});
      rmem[rptr] = wbuf[i];
      rptr++;
    end
    i2c_stop();
    wq();
    chk({tag, "_busy_off"}, bus.BUSY, 0);
    chk_stb(tag);
  endtask

  task automatic read_body(input string tag, input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, d);
      chk({tag, "_rdata"}, d, rmem[rptr]);
      rptr++;
    end
    chk({tag, "_released"}, bus.I2C_SDA_OE, 0);
    i2c_stop();
  endtask

  task automatic read_txn(input string tag, input logic [7:0] p, input int n);
    logic ack;
    i2c_start();
    wr_byte(8'h72, ack);
    chk({tag, "_addr_ack"}, ack, 0);
    wr_byte(p, ack);
    chk({tag, "_reg_ack"}, ack, 0);
    rptr = p;
    i2c_start();
    wr_byte(8'h73, ack);
    chk({tag, "_raddr_ack"}, ack, 0);
    read_body(tag, n);
  endtask

  task automatic cur_read(input string tag, input int n);
    logic ack;
    i2c_start();
    wr_byte(8'h73, ack);
    chk({tag, "_raddr_ack"}, ack, 0);
    read_body(tag, n);
  endtask

  initial begin
    logic ack, r;
    logic [7:0] p;
    int n;

    rst_n = 1'b0;
    scl = 1'b1;
    m_sda = 1'b1;
    gl = 1'b0;
    glitch_arm = 1'b0;
    oe_seen = 0;
    busy_seen = 0;
    oe_viol = 0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_oe", bus.I2C_SDA_OE, 0);
    chk("rst_stb", bus.WR_STB, 0);
    chk("rst_waddr", bus.WR_ADDR, 0);
    chk("rst_wdata", bus.WR_DATA, 0);
    chk("rst_busy", bus.BUSY, 0);
    rst_n = 1'b1;
    wq();

    wbuf[0] = 8'h10; wbuf[1] = 8'h20;
    write_txn("burst", 8'h41, 2);

    read_txn("rdrep", 8'h41, 2);
    cur_read("ptr43", 1);

    oe_seen = 0;
    busy_seen = 0;
    i2c_start();
    wr_byte(8'h74, ack);
    chk("mis_addr_nack", ack, 1);
    wr_byte(8'h41, ack);
    chk("mis_reg_nack", ack, 1);
    wr_byte(8'h55, ack);
    chk("mis_data_nack", ack, 1);
    i2c_stop();
    wq();
    chk("mis_oe_never", oe_seen, 0);
    chk("mis_busy_never", busy_seen, 0);
    chk_stb("mis");

    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    write_txn("wrap", 8'hFF, 2);
    read_txn("wrap_rd", 8'hFF, 2);

    i2c_start();
    wr_byte(8'h72, ack);
    chk("abort_addr_ack", ack, 0);
    wr_byte(8'h50, ack);
    chk("abort_reg_ack", ack, 0);
    rptr = 8'h50;
    bit_xfer(1'b1, r);
    bit_xfer(1'b0, r);
    bit_xfer(1'b1, r);
    bit_xfer(1'b1, r);
    i2c_stop();
    wq();
    chk("abort_busy", bus.BUSY, 0);
    chk_stb("abort");
    cur_read("abort_rd", 1);

    glitch_arm = 1'b1;
    wbuf[0] = 8'hFF;
    write_txn("glitch", 8'h60, 1);
    read_txn("glitch_rd", 8'h60, 1);

    for (int k = 0; k < 6; k++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      write_txn("rnd_wr", p, n);
      read_txn("rnd_rd", p, n);
    end

    wbuf[0] = 8'h05;
    write_txn("prst", 8'h30, 1);
    i2c_start();
    wr_byte(8'h72, ack);
    chk("mrst_addr_ack", ack, 0);
    wr_byte(8'h30, ack);
    chk("mrst_reg_ack", ack, 0);
    i2c_start();
    wr_byte(8'h73, ack);
    chk("mrst_raddr_ack", ack, 0);
    chk("mrst_oe_driving", bus.I2C_SDA_OE, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_oe_async", bus.I2C_SDA_OE, 0);
    chk("mrst_busy", bus.BUSY, 0);
    repeat (3) @(negedge clk);
    m_sda = 1'b1;
    scl = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wq();
    model_reset();
    stb_q.delete();
    exp_q.delete();
    cur_read("post_ptr0", 1);
    read_txn("post_41", 8'h41, 2);
    read_txn("post_ff", 8'hFF, 2);
    read_txn("post_30", 8'h30, 1);
    chk_stb("post");

    chk("oe_change_scl_high", oe_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
